// File: rtl/tracker_pkg.sv
// Shared types for the light-tracking axis controller: FSM state encoding,
// pwm_control direction codes and the registered output bundle.
package tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_DECIDE   = 3'd2,
    ST_MOVE_CW  = 3'd3,
    ST_MOVE_CCW = 3'd4
  } tracker_state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  typedef struct packed {
    logic       en;
    logic [1:0] dir;
    logic       max_en;
  } tracker_out_t;

  // Output decode for a given state; with a latched position the servo is
  // held at pulseWidth_max while sampling and deciding.
  function automatic tracker_out_t decode_out(input tracker_state_e st,
                                              input logic has_pos);
    tracker_out_t o;
    o = '{en: 1'b0, dir: DIR_STOP, max_en: 1'b0};
    case (st)
      ST_COLLECT, ST_DECIDE: if (has_pos) o = '{en: 1'b1, dir: DIR_CCW, max_en: 1'b1};
      ST_MOVE_CW:            o = '{en: 1'b1, dir: DIR_CW,  max_en: 1'b0};
      ST_MOVE_CCW:           o = '{en: 1'b1, dir: DIR_CCW, max_en: 1'b0};
      default:               o = '{en: 1'b0, dir: DIR_STOP, max_en: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ldr_avg.sv
// Per-channel sample accumulator: sums 2^AVG_LOG2 samples, flags full,
// and clears synchronously whenever the controller is not collecting.
module ldr_avg #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       clr,
  input  logic                       sample_en,
  input  logic [DATA_W-1:0]          data,
  output logic [DATA_W+AVG_LOG2-1:0] acc,
  output logic                       full,
  output logic                       last
);

  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] N_M1      = CNT_W'((1 << AVG_LOG2) - 1);

  logic [CNT_W-1:0] cnt;

  assign full = (cnt == N_SAMPLES);
  // High in the cycle the final sample of the batch is being accepted.
  assign last = sample_en && (cnt == N_M1);

  // Accumulate accepted samples; clear takes priority over accumulation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_en) begin
      acc <= acc + {{AVG_LOG2{1'b0}}, data};
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ldr_tracker_ctrl.sv
// Light-tracking axis decision stage. Averages east/west LDR samples,
// compares against a deadband and drives pwm_control (DIR/EN/max_enable/
// pulseWidth_max), holding the last latched position between moves.
// Optional macro TRACKER_LIMIT_EN: end-stop early exit with clamped latch.
module ldr_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int DEADBAND    = 64,
  parameter int MOVE_CYCLES = 4000,
  parameter int MIN_PW      = 50,
  parameter int MAX_PW      = 250
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              adc_valid,
  input  logic              adc_channel,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_ready,
  input  logic [31:0]       pulseWidth,
  output logic [1:0]        DIR,
  output logic              EN,
  output logic              max_enable,
  output logic [31:0]       pulseWidth_max,
  output tracker_state_e    state_dbg
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int MC_W  = ($clog2(MOVE_CYCLES) > 0) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MOVE_CYCLES - 1);
  localparam logic signed [DATA_W:0] DB_POS = (DATA_W+1)'(DEADBAND);
  localparam logic signed [DATA_W:0] DB_NEG = -DB_POS;
  localparam logic [31:0] PW_MIN = 32'(MIN_PW);
  localparam logic [31:0] PW_MAX = 32'(MAX_PW);
`ifdef TRACKER_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  tracker_state_e    state;
  logic              has_pos;
  logic [MC_W-1:0]   move_cnt;
  tracker_out_t      outs;
  logic [ACC_W-1:0]  acc0, acc1;
  logic              full0, full1, last0, last1;
  logic              take0, take1, clr_acc, collect_done;
  logic signed [DATA_W:0] diff;
  logic              cw_limit, ccw_limit, cw_exit, ccw_exit;

  // ADC handshake: a sample transfers on a cycle where adc_valid and
  // adc_ready are both high. adc_ready is only high in COLLECT while the
  // addressed channel still needs samples; a withheld sample stays with
  // the producer (valid held) until it is accepted.
  assign adc_ready = (state == ST_COLLECT) && !(adc_channel ? full1 : full0);
  assign take0     = adc_valid && adc_ready && !adc_channel;
  assign take1     = adc_valid && adc_ready &&  adc_channel;

  // Accumulators sit cleared outside COLLECT, so every batch starts at zero.
  assign clr_acc      = (state != ST_COLLECT);
  assign collect_done = (full0 || last0) && (full1 || last1);

  ldr_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_avg_east (
    .CLK(CLK), .RST(RST), .clr(clr_acc), .sample_en(take0), .data(adc_data),
    .acc(acc0), .full(full0), .last(last0)
  );

  ldr_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_avg_west (
    .CLK(CLK), .RST(RST), .clr(clr_acc), .sample_en(take1), .data(adc_data),
    .acc(acc1), .full(full1), .last(last1)
  );

  // East minus west average; positive means the sun is further east.
  assign diff = $signed({1'b0, DATA_W'(acc0 >> AVG_LOG2)})
              - $signed({1'b0, DATA_W'(acc1 >> AVG_LOG2)});

  assign cw_limit  = LIMIT_ON && (pulseWidth >= PW_MAX);
  assign ccw_limit = LIMIT_ON && (pulseWidth <= PW_MIN);
  assign cw_exit   = cw_limit  || (move_cnt == MC_LAST);
  assign ccw_exit  = ccw_limit || (move_cnt == MC_LAST);

  assign EN         = outs.en;
  assign DIR        = outs.dir;
  assign max_enable = outs.max_en;
  assign state_dbg  = state;

  // Control FSM with outputs registered alongside each state transition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= ST_IDLE;
      has_pos        <= 1'b0;
      move_cnt       <= '0;
      outs           <= decode_out(ST_IDLE, 1'b0);
      pulseWidth_max <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_COLLECT;
          outs  <= decode_out(ST_COLLECT, has_pos);
        end
        ST_COLLECT: begin
          if (collect_done) begin
            state <= ST_DECIDE;
            outs  <= decode_out(ST_DECIDE, has_pos);
          end
        end
        ST_DECIDE: begin
          if (diff > DB_POS) begin
            state <= ST_MOVE_CW;
            outs  <= decode_out(ST_MOVE_CW, has_pos);
          end else if (diff < DB_NEG) begin
            state <= ST_MOVE_CCW;
            outs  <= decode_out(ST_MOVE_CCW, has_pos);
          end else begin
            state <= ST_COLLECT;
            outs  <= decode_out(ST_COLLECT, has_pos);
          end
        end
        ST_MOVE_CW: begin
          if (cw_exit) begin
            state          <= ST_COLLECT;
            has_pos        <= 1'b1;
            move_cnt       <= '0;
            outs           <= decode_out(ST_COLLECT, 1'b1);
            pulseWidth_max <= cw_limit ? PW_MAX : pulseWidth;
          end else begin
            move_cnt <= move_cnt + MC_W'(1);
          end
        end
        ST_MOVE_CCW: begin
          if (ccw_exit) begin
            state          <= ST_COLLECT;
            has_pos        <= 1'b1;
            move_cnt       <= '0;
            outs           <= decode_out(ST_COLLECT, 1'b1);
            pulseWidth_max <= ccw_limit ? PW_MIN : pulseWidth;
          end else begin
            move_cnt <= move_cnt + MC_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          outs  <= decode_out(ST_IDLE, has_pos);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldr_tracker_ctrl.sv
// Directed bench for ldr_tracker_ctrl: reset, deadband edges, averaging,
// CW/CCW move length and hold latch, back-pressure, reset mid-move and
// (with TRACKER_LIMIT_EN) the end-stop clamp.
module tb_ldr_tracker_ctrl;
  import tracker_pkg::*;

  localparam int MOVE_CYCLES = 4000;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           adc_valid = 1'b0;
  logic           adc_channel = 1'b0;
  logic [11:0]    adc_data = '0;
  logic           adc_ready;
  logic [31:0]    pulseWidth = 32'd100;
  logic [1:0]     DIR;
  logic           EN;
  logic           max_enable;
  logic [31:0]    pulseWidth_max;
  tracker_state_e state_dbg;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic        exp_has_pos = 1'b0;

  typedef struct {
    logic [3:0][11:0] s0;
    logic [11:0]      s1;
    int               mv;   // 0 none, 1 CW, 2 CCW
    string            name;
  } vec_t;

  vec_t vecs[8];

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ldr_tracker_ctrl dut (
    .CLK(CLK), .RST(RST),
    .adc_valid(adc_valid), .adc_channel(adc_channel), .adc_data(adc_data),
    .adc_ready(adc_ready), .pulseWidth(pulseWidth),
    .DIR(DIR), .EN(EN), .max_enable(max_enable),
    .pulseWidth_max(pulseWidth_max), .state_dbg(state_dbg)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic en, input logic [1:0] dir,
                            input logic maxen);
    check({nm, "_en"},  32'(EN), 32'(en));
    check({nm, "_dir"}, 32'(DIR), 32'(dir));
    check({nm, "_max_enable"}, 32'(max_enable), 32'(maxen));
  endtask

  task automatic expect_rest_outs(input string nm);
    if (exp_has_pos) check_outs(nm, 1'b1, 2'b10, 1'b1);
    else             check_outs(nm, 1'b0, 2'b00, 1'b0);
  endtask

  // Driver: call just after a rising edge; returns just after the accepting edge.
  task automatic send_sample(input logic ch, input logic [11:0] d);
    int waited;
    waited      = 0;
    adc_valid   = 1'b1;
    adc_channel = ch;
    adc_data    = d;
    @(negedge CLK);
    while (!adc_ready && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    check("sample_ready_in_budget", 32'(adc_ready), 32'd1);
    @(posedge CLK);
    #1;
    adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_has_pos = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vector(input vec_t v);
    int          cnt;
    logic [31:0] last_pw;
    logic [1:0]  mdir;
    for (int i = 0; i < 4; i++) begin
      send_sample(1'b0, v.s0[i]);
      send_sample(1'b1, v.s1);
    end
    @(negedge CLK);
    check({v.name, "_decide"}, 32'(state_dbg), 32'(ST_DECIDE));
    expect_rest_outs({v.name, "_decide_outs"});
    @(posedge CLK);
    #1;
    if (v.mv == 0) begin
      @(negedge CLK);
      check({v.name, "_back_to_collect"}, 32'(state_dbg), 32'(ST_COLLECT));
      expect_rest_outs({v.name, "_nomove_outs"});
    end else begin
      mdir    = (v.mv == 1) ? 2'b01 : 2'b10;
      cnt     = 0;
      last_pw = pulseWidth;
      forever begin
        @(negedge CLK);
        if (!(EN === 1'b1 && DIR === mdir && max_enable === 1'b0) ||
            cnt >= MOVE_CYCLES + 100) break;
        cnt++;
        last_pw = pulseWidth;
        @(posedge CLK);
        #1;
        pulseWidth = 32'(100 + cnt % 50);
      end
      exp_q.push_back(last_pw);
      check({v.name, "_move_len"}, 32'(cnt), 32'(MOVE_CYCLES));
      exp_has_pos = 1'b1;
      check_outs({v.name, "_hold"}, 1'b1, 2'b10, 1'b1);
      check({v.name, "_pw_max"}, pulseWidth_max, exp_q.pop_front());
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0] = '{{4{12'd1064}}, 12'd1000, 0, "db_edge_pos"};
    vecs[1] = '{{4{12'd1065}}, 12'd1000, 1, "db_plus1_cw"};
    vecs[2] = '{{12'd1065, 12'd1065, 12'd1065, 12'd1064}, 12'd1000, 0, "avg_floor"};
    vecs[3] = '{{12'd1070, 12'd1060, 12'd1067, 12'd1063}, 12'd1000, 1, "avg_mixed_cw"};
    vecs[4] = '{{4{12'd500}},  12'd2000, 2, "ccw_big"};
    vecs[5] = '{{4{12'd1000}}, 12'd1064, 0, "db_edge_neg"};
    vecs[6] = '{{4{12'd1000}}, 12'd1065, 2, "db_minus1_ccw"};
    vecs[7] = '{{4{12'd3000}}, 12'd1000, 1, "cw_big"};

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outs("reset", 1'b0, 2'b00, 1'b0);
    check("reset_pw_max", pulseWidth_max, 32'd0);
    check("reset_ready", 32'(adc_ready), 32'd0);
    RST = 1'b0;
    #1;
    check("release_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("release_ready_first", 32'(adc_ready), 32'd0);
    @(negedge CLK);
    check("release_ready_second", 32'(adc_ready), 32'd1);
    @(posedge CLK);
    #1;

    // Table of decision vectors
    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Back-pressure: fifth east sample waits for the next COLLECT
    for (int i = 0; i < 4; i++) send_sample(1'b0, 12'd2000);
    adc_valid = 1'b1; adc_channel = 1'b0; adc_data = 12'd2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_full_ready", 32'(adc_ready), 32'd0);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) send_sample(1'b1, 12'd2000);
    adc_valid = 1'b1; adc_channel = 1'b0; adc_data = 12'd2000;
    @(negedge CLK);
    check("bp_decide_ready", 32'(adc_ready), 32'd0);
    expect_rest_outs("bp_decide_outs");
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("bp_next_collect_ready", 32'(adc_ready), 32'd1);
    @(posedge CLK);
    #1;
    adc_valid = 1'b0;

    // Reset in the middle of a CW move
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_sample(1'b0, 12'd3000);
      send_sample(1'b1, 12'd1000);
    end
    @(negedge CLK);
    check("rstmove_decide", 32'(state_dbg), 32'(ST_DECIDE));
    repeat (100) @(posedge CLK);
    #2;
    check("rstmove_pre_dir", 32'(DIR), 32'd1);
    RST = 1'b1;
    #1;
    check_outs("rstmove_async", 1'b0, 2'b00, 1'b0);
    check("rstmove_ready", 32'(adc_ready), 32'd0);
    check("rstmove_pw_max", pulseWidth_max, 32'd0);
    check("rstmove_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge CLK);
    RST = 1'b0;
    exp_has_pos = 1'b0;
    @(posedge CLK);
    #1;
    // has_pos cleared: a no-move decision must leave outputs stopped
    begin
      vec_t v;
      v = '{{4{12'd1000}}, 12'd1000, 0, "post_rst_nomove"};
      run_vector(v);
    end

`ifdef TRACKER_LIMIT_EN
    // End stop: pulse width past MAX_PW ends the move and latches MAX_PW
    pulseWidth = 32'd100;
    for (int i = 0; i < 4; i++) begin
      send_sample(1'b0, 12'd3000);
      send_sample(1'b1, 12'd1000);
    end
    @(posedge CLK);
    #1;
    repeat (9) @(posedge CLK);
    #1;
    pulseWidth = 32'd260;
    @(negedge CLK);
    check("limit_still_moving_dir", 32'(DIR), 32'd1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_outs("limit_hold", 1'b1, 2'b10, 1'b1);
    exp_q.push_back(32'd250);
    check("limit_pw_max", pulseWidth_max, exp_q.pop_front());
    pulseWidth = 32'd100;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ldr_tracker_ctrl.md
# ldr_tracker_ctrl

Closed-loop decision stage for the light-tracking axis. It consumes ADC samples from the two light sensors (channel 0 = east, channel 1 = west), averages each channel, and compares the averages against a deadband. It then drives `pwm_control` directly through its `DIR`, `EN`, `max_enable` and `pulseWidth_max` inputs, using `pwm_control`'s `pulseWidth` output as position feedback. Between moves it holds the servo at the last latched position.

## Interface
Parameters:
- `DATA_W`, 12, ADC sample width (unsigned).
- `AVG_LOG2`, 2, log2 of the number of samples averaged per channel per decision.
- `DEADBAND`, 64, minimum |avg0 − avg1| (ADC LSBs) that triggers a move.
- `MOVE_CYCLES`, 4000, `CLK` cycles per move burst.
- `MIN_PW`, 50, lower pulse-width end stop, matching `pwm_control` `minPulseWidth`.
- `MAX_PW`, 250, upper pulse-width end stop, matching `pwm_control` `maxPulseWidth`.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `adc_valid`  in  1  sample present.
- `adc_channel`  in  1  0 = east, 1 = west.
- `adc_data`  in  `DATA_W`  sample value.
- `adc_ready`  out  1  sample accepted this cycle when high together with `adc_valid`.
- `pulseWidth`  in  32  current servo pulse width from `pwm_control`.
- `DIR`  out  2  00 stop, 01 CW (pulse width rising), 10 CCW/hold.
- `EN`  out  1  `pwm_control` enable.
- `max_enable`  out  1  hold-at-`pulseWidth_max` request.
- `pulseWidth_max`  out  32  latched hold position.

## Operation
- FSM states: IDLE, COLLECT, DECIDE, MOVE_CW, MOVE_CCW.
- Reset goes to IDLE and clears `has_pos`. IDLE moves to COLLECT on the next cycle.
- COLLECT
  - Clear both accumulators on entry.
  - Accept a sample when `adc_valid && adc_ready`. `adc_ready` = (state==COLLECT) && !full[`adc_channel`]. It depends combinationally on `adc_channel`.
  - Add `adc_data` into the accumulator for that channel, width `DATA_W+AVG_LOG2`.
  - When both counts reach 2^`AVG_LOG2`, go to DECIDE.
- DECIDE (one cycle)
  - avgN = accN >> `AVG_LOG2`.
  - diff = avg0 − avg1, signed, `DATA_W+1` bits.
  - diff > `DEADBAND` → MOVE_CW.
  - diff < −`DEADBAND` → MOVE_CCW.
  - Otherwise → COLLECT. |diff| == `DEADBAND` does not move.
- MOVE_CW / MOVE_CCW
  - Move counter counts 0..`MOVE_CYCLES`−1, then the state exits.
  - On exit: latch `pulseWidth` into `pulseWidth_max`, set `has_pos`=1, go to COLLECT.
- Output decode:
  - IDLE, or COLLECT/DECIDE with `has_pos`=0: `EN`=0, `DIR`=00, `max_enable`=0.
  - COLLECT/DECIDE with `has_pos`=1: `EN`=1, `DIR`=10, `max_enable`=1 (hold).
  - MOVE_CW: `EN`=1, `DIR`=01, `max_enable`=0.
  - MOVE_CCW: `EN`=1, `DIR`=10, `max_enable`=0.
- Once `has_pos`=1, `EN` never drops except on reset. This preserves `pwm_control`'s internal ramp state.

## Timing
- Reset values: `DIR`=00, `EN`=0, `max_enable`=0, `pulseWidth_max`=0, `adc_ready`=0 while `RST`=1. All are registered except `adc_ready`.
- Reset mid-move forces reset values asynchronously. Accumulators, counters and `has_pos` are cleared.
- Decision latency: DECIDE occurs 1 cycle after the last accepted sample. MOVE outputs appear the cycle after DECIDE.
- Move length is exactly `MOVE_CYCLES` cycles of `DIR`=01/10 with `max_enable`=0.
- Hold outputs and the new `pulseWidth_max` appear together on the first COLLECT cycle after the move.
- Samples offered outside COLLECT, or to a full channel, are back-pressured (`adc_ready`=0) and are not dropped.

## Configuration
- `TRACKER_LIMIT_EN` defined: MOVE_CW exits early when `pulseWidth` ≥ `MAX_PW`, and MOVE_CCW exits early when `pulseWidth` ≤ `MIN_PW`. The exit latches the clamped value (`MAX_PW` or `MIN_PW`) into `pulseWidth_max`.
- `TRACKER_LIMIT_EN` undefined: moves always run the full `MOVE_CYCLES` and latch raw `pulseWidth`.

## Structure
- `tracker_pkg` holds:
  - state enum;
  - DIR constants `DIR_STOP`=2'b00, `DIR_CW`=2'b01, `DIR_CCW`=2'b10.
- Sub-module `ldr_avg` (one instance per channel) contains the accumulator, sample counter, `full` flag and synchronous clear. The FSM, deadband compare and output decode stay in the top level.

## Test plan
- Reset: assert `RST` → `DIR`=00, `EN`=0, `max_enable`=0, `pulseWidth_max`=0, `adc_ready`=0. Release → `adc_ready`=1 from the second cycle.
- CW move: 4× ch0=3000 and 4× ch1=1000 → DECIDE, then `DIR`=01, `EN`=1 for exactly 4000 cycles. Then `DIR`=10, `max_enable`=1, and `pulseWidth_max` equals `pulseWidth` at the exit cycle.
- Deadband edge: ch0=1064, ch1=1000 (diff=64) → no move, outputs stay stop/disabled. Repeat with ch0=1065 → MOVE_CW.
- CCW move: ch0=500, ch1=2000 → `DIR`=10 with `max_enable`=0 for 4000 cycles, then hold.
- Limit (`TRACKER_LIMIT_EN`): during MOVE_CW drive `pulseWidth`=250 → next cycle hold with `pulseWidth_max`=250, well before 4000 cycles.
- Back-pressure and reset: offer a 5th ch0 sample → `adc_ready`=0 until the next COLLECT. Assert `RST` mid-MOVE_CW → outputs return to reset values within the same cycle.
